// File: rtl/wb_inst_feeder_if.sv
// Bundle between the instruction feeder and its users: instruction push port,
// the core's Wishbone request/response, captured-write monitor port and queue level.
interface wb_inst_feeder_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          i_inst_valid;
    logic [31:0]   i_inst;
    logic          o_inst_ready;

    logic [31:0]   i_wb_adr;
    logic [15:0]   i_wb_sel;
    logic          i_wb_we;
    logic [127:0]  i_wb_dat;
    logic          i_wb_cyc;
    logic          i_wb_stb;
    logic [127:0]  o_wb_dat;
    logic          o_wb_ack;
    logic          o_wb_err;

    logic          o_res_valid;
    logic [31:0]   o_res_adr;
    logic [127:0]  o_res_data;
    logic [15:0]   o_res_sel;

    logic [LW-1:0] o_level;

    modport slave (
        input  i_inst_valid, i_inst,
        input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        output o_inst_ready, o_wb_dat, o_wb_ack, o_wb_err,
        output o_res_valid, o_res_adr, o_res_data, o_res_sel, o_level
    );

    modport master (
        output i_inst_valid, i_inst,
        output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        input  o_inst_ready, o_wb_dat, o_wb_ack, o_wb_err,
        input  o_res_valid, o_res_adr, o_res_data, o_res_sel, o_level
    );
endinterface

// File: rtl/wb_inst_feeder.sv
// Instruction queue that answers a core's 128-bit Wishbone fetches and captures its writes.
// Define WB_FEEDER_EMPTY_ERR_EN to answer reads of an empty queue with err instead of a NOP line.
module wb_inst_feeder #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] NOP_WORD = 32'hF0801003,
    parameter int          ACK_LAT  = 1
) (
    input logic           i_clk,
    input logic           i_rst,
    wb_inst_feeder_if.slave bus
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 32;
    localparam int AW        = $clog2(DEPTH);
    localparam int LW        = AW + 1;
    localparam logic [1:0] CNT_INIT = (ACK_LAT == 0) ? 2'd0 : 2'(ACK_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [1:0]      cnt, cnt_nx;
    logic            req_we;
    logic [31:0]     req_adr;

    logic [VEC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic             full, empty, push, pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign push  = bus.i_inst_valid && !full;
    assign pop   = (state == RESP) && !req_we && !empty;

    assign bus.o_inst_ready = !full;
    assign bus.o_level      = level;

    // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= bus.i_inst;
    end

    logic accept;
    assign accept = bus.i_wb_cyc && bus.i_wb_stb;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_nx = (ACK_LAT == 0) ? RESP : WAIT;
                cnt_nx   = CNT_INIT;
            end
            WAIT: begin
                if (!accept)         state_nx = IDLE;
                else if (cnt == '0)  state_nx = RESP;
                else                 cnt_nx   = cnt - 1'b1;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request attributes come from the accept cycle; with ACK_LAT=0 that is the cycle
    // before RESP, so the capture path must look through to the live bus.
    logic        cap, we_now;
    logic [31:0] adr_now;
    assign we_now  = (state == IDLE) ? bus.i_wb_we  : req_we;
    assign adr_now = (state == IDLE) ? bus.i_wb_adr : req_adr;
    assign cap     = (state_nx == RESP) && (state != RESP) && we_now;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            req_we          <= 1'b0;
            req_adr         <= '0;
            bus.o_res_valid <= 1'b0;
            bus.o_res_adr   <= '0;
            bus.o_res_data  <= '0;
            bus.o_res_sel   <= '0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            bus.o_res_valid <= cap;
            if (state == IDLE && accept) begin
                req_we  <= bus.i_wb_we;
                req_adr <= bus.i_wb_adr;
            end
            if (cap) begin
                bus.o_res_adr  <= adr_now;
                bus.o_res_data <= bus.i_wb_dat;
                bus.o_res_sel  <= bus.i_wb_sel;
            end
        end
    end

    // Read line: lane 0 carries the queue head, all other lanes (or all, if empty) carry NOP.
    logic [NUM_LANES-1:0][VEC_W-1:0] line;
    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            if (g == 0) begin : g_head
                assign line[g] = empty ? NOP_WORD : mem[rd_ptr];
            end else begin : g_nop
                assign line[g] = NOP_WORD;
            end
        end
    endgenerate

    always_comb begin
        bus.o_wb_ack = 1'b0;
        bus.o_wb_err = 1'b0;
        bus.o_wb_dat = '0;
        if (state == RESP) begin
            if (req_we) begin
                bus.o_wb_ack = 1'b1;
            end else if (!empty) begin
                bus.o_wb_ack = 1'b1;
                bus.o_wb_dat = line;
            end else begin
`ifdef WB_FEEDER_EMPTY_ERR_EN
                bus.o_wb_err = 1'b1;
`else
                bus.o_wb_ack = 1'b1;
                bus.o_wb_dat = line;
`endif
            end
        end
    end
endmodule
